decode_stage: RTL
=================

# decode_stage

Registered, flow-controlled instruction decode stage for the RV32I/RV64I core. It sits between fetch and execute. It splits each accepted instruction into opcode, funct, register, immediate and type fields, flags illegal encodings, and carries the PC alongside. A 2-entry skid buffer registers `in_ready` (no combinational path from `out_ready`) while sustaining 1 instruction/cycle throughput.

## Interface
- `XLEN`, 32, datapath width: 32 or 64. Sets `i_pc`/`o_pc`/`o_imm` width; 64 also enables OP-IMM-32/OP-32.
- `EN_FENCE`, 1, recognise MISC-MEM (0001111) as I-type; when 0 it is illegal.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clk_en`  in  1  stage enable; when 0 all state holds.
- `flush`  in  1  discard all buffered instructions.
- `i_valid`  in  1  fetch has an instruction.
- `o_ready`  out  1  stage can accept.
- `i_instruction`  in  32  raw instruction.
- `i_pc`  in  XLEN  its PC.
- `o_valid`  out  1  decoded bundle present.
- `i_ready`  in  1  execute accepts.
- `o_opcode`  out  7; `o_funct7` out 7; `o_funct3` out 3; `o_rs1`/`o_rs2`/`o_rd` out 5 each.
- `o_imm`  out  XLEN  sign-extended immediate.
- `o_inst_type`  out  `inst_type_e`  R/I/S/B/U/J/ERROR.
- `o_illegal`  out  1  unrecognised encoding.
- `o_instruction`  out  32  raw word, for mtval.
- `o_pc`  out  XLEN.

## Operation
- Type map:
  - R: 0110011.
  - I: 0010011, 0000011, 1100111, 1110011, 0001111 (if `EN_FENCE`).
  - S: 0100011. B: 1100011. J: 1101111. U: 0110111, 0010111.
  - XLEN=64 only: 0011011 is I, 0111011 is R.
  - Anything else, including bits[1:0]≠11, is ERROR with `o_illegal`=1.
- Field rules:
  - Every field not defined for the type is zero.
  - ERROR: all fields and `o_imm` are zero; `o_opcode`, `o_instruction` and `o_pc` are still valid.
- Immediates, all sign-extended from instr[31] to XLEN:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}, sign-extended above bit 31 when XLEN=64.
  - J: {[31],[19:12],[20],[30:21],0}.
- Buffer:
  - Entries are `main` (drives the outputs) and `skid`. Both are stored already decoded.
  - A transfer occurs when valid && ready && `clk_en`.
  - Input transfer with `main` empty, or `main` draining the same cycle → write `main`. Otherwise write `skid`.
  - Output transfer with `skid` full → `skid` moves to `main`.
- `o_ready` = !skid_full, registered. `o_ready` and `o_valid` are forced to 0 while `clk_en`=0.
- Flush: both entries are invalidated at the edge, and any input offered that cycle is dropped. The next cycle `o_ready`=1 and `o_valid`=0. Flush is ignored while `clk_en`=0.
- Order is strictly FIFO; no instruction is duplicated or lost.

## Timing
- Reset values: `o_valid`=0, `o_ready`=1, all data outputs 0, `o_inst_type`=ERROR.
- Reset is asynchronous. Mid-operation it drops everything in flight immediately.
- Latency is 1 cycle: an instruction accepted at edge N is on the outputs after edge N.
- Throughput is 1/cycle with `i_ready` held at 1.
- Back-pressure:
  - With `i_ready`=0, at most 2 instructions are accepted.
  - `o_ready` falls the cycle after `skid` fills.
  - `o_ready` rises the cycle after the first drain.
- Simultaneous input and output transfer with `skid` full is impossible, because `o_ready`=0.
- Outputs are stable while `o_valid` && !`i_ready`.

## Structure
- `decode_pkg` holds:
  - `inst_type_e` (ERROR = 0, so `|type` means decodable);
  - opcode localparams;
  - `decoded_t`, a packed struct of all output fields parametrised by XLEN via typedef in the module.
- Sub-module `decode_fields`: purely combinational raw → `decoded_t` with the type map, immediate rules and zeroing. It is instantiated once on the input side.
- The skid buffer and control live in `decode_stage`.

## Test plan
- Single-instruction decode:
  - Reset, then push 0xFFF00093 (addi x1,x0,-1) → next cycle `o_valid`=1, type I, rd=1, rs1=0, funct3=0, imm=0xFFFFFFFF, rs2=funct7=0.
  - Push 0xFE000EE3 (beq x0,x0,-4) → type B, imm=0xFFFFFFFC, rd=0.
- Back-pressure: hold `i_ready`=0 and offer 3 instructions back-to-back → first 2 accepted, `o_ready`=0 from the 3rd cycle. Release `i_ready` → outputs appear in push order, each exactly once.
- Flush: load 2 entries, assert `flush` with a third offered → next cycle `o_valid`=0, `o_ready`=1, and the third never appears.
- Illegal encodings: push 0x00000000 and 0x0000007F → `o_illegal`=1, type ERROR, all fields 0, `o_instruction` echoed.
- XLEN=64: push 0xFFF0809B (addiw x1,x1,-1) → type I, imm=64'hFFFF_FFFF_FFFF_FFFF. At XLEN=32 the same word gives `o_illegal`=1.
- Control interactions:
  - `clk_en`=0 for 3 cycles mid-stream → `o_ready`=`o_valid`=0 and state is unchanged on resume.
  - Assert `rst` between edges with 2 entries held → outputs clear immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and opcode constants for the RV32I/RV64I decode stage.
package decode_pkg;

   // TYPE_ERROR is zero so that a non-zero type means "decodable".
   typedef enum logic [2:0] {
      TYPE_ERROR = 3'd0,
      TYPE_R     = 3'd1,
      TYPE_I     = 3'd2,
      TYPE_S     = 3'd3,
      TYPE_B     = 3'd4,
      TYPE_U     = 3'd5,
      TYPE_J     = 3'd6
   } inst_type_e;

   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   // XLEN-independent part of a decoded bundle; the XLEN-wide fields are
   // added by the typedef inside decode_stage.
   typedef struct packed {
      logic [6:0] opcode;
      logic [6:0] funct7;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      inst_type_e inst_type;
      logic       illegal;
   } dec_fields_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RISC-V field splitter: raw word -> typed fields and
// sign-extended immediate, with undefined fields forced to zero.
module decode_fields
   import decode_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter bit          EN_FENCE = 1'b1
) (
   input  logic [31:0]     instr_i,
   output dec_fields_t     fields_o,
   output logic [XLEN-1:0] imm_o
);

   inst_type_e  itype;
   logic [31:0] imm32;

   always_comb begin
      unique case (instr_i[6:0])
         OPC_OP:                                      itype = TYPE_R;
         OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:  itype = TYPE_I;
         OPC_MISC_MEM:  itype = EN_FENCE ? TYPE_I : TYPE_ERROR;
         OPC_STORE:                                   itype = TYPE_S;
         OPC_BRANCH:                                  itype = TYPE_B;
         OPC_JAL:                                     itype = TYPE_J;
         OPC_LUI, OPC_AUIPC:                          itype = TYPE_U;
         OPC_OP_IMM_32: itype = (XLEN == 64) ? TYPE_I : TYPE_ERROR;
         OPC_OP_32:     itype = (XLEN == 64) ? TYPE_R : TYPE_ERROR;
         default:                                     itype = TYPE_ERROR;
      endcase
   end

   always_comb begin
      fields_o           = '0;
      fields_o.opcode    = instr_i[6:0];
      fields_o.inst_type = itype;
      fields_o.illegal   = (itype == TYPE_ERROR);
      imm32              = '0;
      unique case (itype)
         TYPE_R: begin
            fields_o.funct7 = instr_i[31:25];
            fields_o.rs2    = instr_i[24:20];
            fields_o.rs1    = instr_i[19:15];
            fields_o.funct3 = instr_i[14:12];
            fields_o.rd     = instr_i[11:7];
         end
         TYPE_I: begin
            fields_o.rs1    = instr_i[19:15];
            fields_o.funct3 = instr_i[14:12];
            fields_o.rd     = instr_i[11:7];
            imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
         end
         TYPE_S: begin
            fields_o.rs2    = instr_i[24:20];
            fields_o.rs1    = instr_i[19:15];
            fields_o.funct3 = instr_i[14:12];
            imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
         end
         TYPE_B: begin
            fields_o.rs2    = instr_i[24:20];
            fields_o.rs1    = instr_i[19:15];
            fields_o.funct3 = instr_i[14:12];
            imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
         end
         TYPE_U: begin
            fields_o.rd = instr_i[11:7];
            imm32 = {instr_i[31:12], 12'b0};
         end
         TYPE_J: begin
            fields_o.rd = instr_i[11:7];
            imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
         end
         default: ;
      endcase
      // Every 32-bit immediate above already carries instr[31] in bit 31.
      imm_o = XLEN'($signed(imm32));
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with a 2-entry skid buffer (main drives the
// outputs, skid absorbs one extra word so o_ready can be registered).
module decode_stage
   import decode_pkg::*;
#(
   parameter int unsigned XLEN     = 32,
   parameter bit          EN_FENCE = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_en,
   input  logic            flush,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_instruction,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [6:0]      o_opcode,
   output logic [6:0]      o_funct7,
   output logic [2:0]      o_funct3,
   output logic [4:0]      o_rs1,
   output logic [4:0]      o_rs2,
   output logic [4:0]      o_rd,
   output logic [XLEN-1:0] o_imm,
   output inst_type_e      o_inst_type,
   output logic            o_illegal,
   output logic [31:0]     o_instruction,
   output logic [XLEN-1:0] o_pc
);

   typedef struct packed {
      dec_fields_t     f;
      logic [XLEN-1:0] imm;
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
   } decoded_t;

   dec_fields_t     fields_in;
   logic [XLEN-1:0] imm_in;
   decoded_t        dec_in;

   decoded_t main_q, main_d, skid_q, skid_d;
   logic     main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic     rdy_q, rdy_d;
   logic     in_xfer, out_xfer;

   decode_fields #(
      .XLEN     (XLEN),
      .EN_FENCE (EN_FENCE)
   ) u_fields (
      .instr_i  (i_instruction),
      .fields_o (fields_in),
      .imm_o    (imm_in)
   );

   assign dec_in = '{f: fields_in, imm: imm_in, instr: i_instruction, pc: i_pc};

   assign o_ready  = rdy_q & clk_en;
   assign o_valid  = main_vld_q & clk_en;
   assign in_xfer  = i_valid & o_ready;
   assign out_xfer = o_valid & i_ready;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (clk_en && flush) begin
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         if (out_xfer) begin
            if (skid_vld_q) begin
               main_d     = skid_q;
               skid_vld_d = 1'b0;
            end else begin
               main_vld_d = 1'b0;
            end
         end
         // Incoming word lands in main if it is empty or emptying without a skid refill.
         if (in_xfer) begin
            if (!main_vld_q || (out_xfer && !skid_vld_q)) begin
               main_d     = dec_in;
               main_vld_d = 1'b1;
            end else begin
               skid_d     = dec_in;
               skid_vld_d = 1'b1;
            end
         end
      end
      rdy_d = !skid_vld_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         rdy_q      <= 1'b1;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         rdy_q      <= rdy_d;
      end
   end

   assign o_opcode      = main_q.f.opcode;
   assign o_funct7      = main_q.f.funct7;
   assign o_funct3      = main_q.f.funct3;
   assign o_rs1         = main_q.f.rs1;
   assign o_rs2         = main_q.f.rs2;
   assign o_rd          = main_q.f.rd;
   assign o_imm         = main_q.imm;
   assign o_inst_type   = main_q.f.inst_type;
   assign o_illegal     = main_q.f.illegal;
   assign o_instruction = main_q.instr;
   assign o_pc          = main_q.pc;

endmodule
